// File: rtl/switch_poller.sv
// Avalon-MM master that periodically reads the switch PIO data register,
// debounces the sampled value and flags every change of the accepted value.
module switch_poller #(
  parameter int unsigned POLL_PERIOD  = 50000,
  parameter int unsigned STABLE_COUNT = 4,
  parameter int unsigned DATA_WIDTH   = 18
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [1:0]            avm_address,
  output logic                  avm_read,
  input  logic [31:0]           avm_readdata,
  output logic [DATA_WIDTH-1:0] sw_value,
  output logic                  sw_valid,
  output logic                  sw_changed
);

  localparam int unsigned CW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned MW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(POLL_PERIOD - 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(STABLE_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WAIT,
    ST_EVAL
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  read_q, read_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic [DATA_WIDTH-1:0] cand_q, cand_d;
  logic                  cand_valid_q, cand_valid_d;
  logic [MW-1:0]         match_q, match_d;
  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  valid_q, valid_d;
  logic                  changed_q, changed_d;
  logic                  accept;

  // Only the low DATA_WIDTH bits of the slave data carry switch state.
  logic [31:0] unused_readdata;
  assign unused_readdata = avm_readdata;

  // Next-state, debounce and output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q == CNT_MAX) ? '0 : cnt_q + CW'(1);
    read_d       = 1'b0;
    sample_d     = sample_q;
    cand_d       = cand_q;
    cand_valid_d = cand_valid_q;
    match_d      = match_q;
    value_d      = value_q;
    valid_d      = valid_q;
    changed_d    = 1'b0;
    accept       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Look one cycle ahead so the strobe lands on counter == POLL_PERIOD-1.
        if (enable && (cnt_d == CNT_MAX)) begin
          state_d = ST_READ;
          read_d  = 1'b1;
        end
      end
      ST_READ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        sample_d = avm_readdata[DATA_WIDTH-1:0];
        state_d  = ST_EVAL;
      end
      ST_EVAL: begin
        state_d = ST_IDLE;
        if (!cand_valid_q || (sample_q != cand_q)) begin
          cand_d       = sample_q;
          cand_valid_d = 1'b1;
          match_d      = '0;
        end else if (match_q < MATCH_MAX) begin
          match_d = match_q + MW'(1);
        end
        // Candidate always equals the sample after the update above.
        accept = (match_d == MATCH_MAX);
        if (accept && (!valid_q || (sample_q != value_q))) begin
          value_d   = sample_q;
          valid_d   = 1'b1;
          changed_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      read_q       <= 1'b0;
      sample_q     <= '0;
      cand_q       <= '0;
      cand_valid_q <= 1'b0;
      match_q      <= '0;
      value_q      <= '0;
      valid_q      <= 1'b0;
      changed_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      read_q       <= read_d;
      sample_q     <= sample_d;
      cand_q       <= cand_d;
      cand_valid_q <= cand_valid_d;
      match_q      <= match_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      changed_q    <= changed_d;
    end
  end

  assign avm_address = 2'b00;
  assign avm_read    = read_q;
  assign sw_value    = value_q;
  assign sw_valid    = valid_q;
  assign sw_changed  = changed_q;

endmodule

// File: tb/tb_switch_poller.sv
// Directed bench for switch_poller with POLL_PERIOD=8, STABLE_COUNT=3.
module tb_switch_poller;

  localparam int P  = 8;
  localparam int DW = 18;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [1:0]    avm_address;
  logic          avm_read;
  logic [31:0]   avm_readdata;
  logic [DW-1:0] sw_value;
  logic          sw_valid;
  logic          sw_changed;

  switch_poller #(
    .POLL_PERIOD (P),
    .STABLE_COUNT(3),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .avm_address (avm_address),
    .avm_read    (avm_read),
    .avm_readdata(avm_readdata),
    .sw_value    (sw_value),
    .sw_valid    (sw_valid),
    .sw_changed  (sw_changed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   rd;
    logic [DW-1:0] val;
    logic          vld;
    logic          chg;
  } vec_t;

  vec_t vecs [17];
  int   checks;
  int   errors;
  int   cyc;
  int   next_strobe;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Wait (bounded) for the next strobe and check its cycle and address.
  task automatic wait_strobe(input string nm);
    int n;
    n = 0;
    while ((avm_read !== 1'b1) && (n < 2 * P)) begin
      next_cycle();
      n++;
    end
    chk({nm, "_cycle"}, 32'(cyc), 32'(next_strobe));
    chk({nm, "_addr"}, 32'(avm_address), 32'd0);
    next_strobe = cyc + P;
  endtask

  // One full poll: strobe at t, outputs checked at t+3, pulse width at t+4.
  task automatic run_poll(input vec_t v, input string nm);
    avm_readdata = v.rd;
    wait_strobe(nm);
    next_cycle();
    chk({nm, "_read_one_cycle"}, 32'(avm_read), 32'd0);
    next_cycle();
    chk({nm, "_no_early_pulse"}, 32'(sw_changed), 32'd0);
    next_cycle();
    chk({nm, "_value"}, 32'(sw_value), 32'(v.val));
    chk({nm, "_valid"}, 32'(sw_valid), 32'(v.vld));
    chk({nm, "_changed"}, 32'(sw_changed), 32'(v.chg));
    next_cycle();
    chk({nm, "_pulse_end"}, 32'(sw_changed), 32'd0);
  endtask

  initial begin
    int   reads;
    vec_t v;

    vecs[0]  = '{32'h0000_0000, 18'h00000, 1'b0, 1'b0};
    vecs[1]  = '{32'h0000_0000, 18'h00000, 1'b0, 1'b0};
    vecs[2]  = '{32'h0000_0000, 18'h00000, 1'b1, 1'b1};
    vecs[3]  = '{32'h0000_0000, 18'h00000, 1'b1, 1'b0};
    vecs[4]  = '{32'h0002_A5A5, 18'h00000, 1'b1, 1'b0};
    vecs[5]  = '{32'h0002_A5A5, 18'h00000, 1'b1, 1'b0};
    vecs[6]  = '{32'h0002_A5A5, 18'h2A5A5, 1'b1, 1'b1};
    vecs[7]  = '{32'h0002_A5A5, 18'h2A5A5, 1'b1, 1'b0};
    vecs[8]  = '{32'h0000_0001, 18'h2A5A5, 1'b1, 1'b0};
    vecs[9]  = '{32'h0000_0000, 18'h2A5A5, 1'b1, 1'b0};
    vecs[10] = '{32'h0000_0001, 18'h2A5A5, 1'b1, 1'b0};
    vecs[11] = '{32'h0000_0001, 18'h2A5A5, 1'b1, 1'b0};
    vecs[12] = '{32'h0000_0001, 18'h00001, 1'b1, 1'b1};
    vecs[13] = '{32'h0000_0001, 18'h00001, 1'b1, 1'b0};
    vecs[14] = '{32'hFFFC_0003, 18'h00001, 1'b1, 1'b0};
    vecs[15] = '{32'hFFFC_0003, 18'h00001, 1'b1, 1'b0};
    vecs[16] = '{32'hFFFC_0003, 18'h00003, 1'b1, 1'b1};

    checks       = 0;
    errors       = 0;
    cyc          = 0;
    reset        = 1'b1;
    enable       = 1'b1;
    avm_readdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    reset       = 1'b0;
    cyc         = 0;
    next_strobe = P - 1;

    chk("rst_value", 32'(sw_value), 32'd0);
    chk("rst_valid", 32'(sw_valid), 32'd0);
    chk("rst_changed", 32'(sw_changed), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_addr", 32'(avm_address), 32'd0);

    for (int i = 0; i < 17; i++) begin
      run_poll(vecs[i], $sformatf("vec%0d", i));
    end

    // Drop enable the cycle after a strobe: that poll still completes.
    avm_readdata = 32'hFFFC_0003;
    wait_strobe("en_strobe");
    next_cycle();
    enable = 1'b0;
    next_cycle();
    next_cycle();
    chk("en_poll_value", 32'(sw_value), 32'h3);
    chk("en_poll_changed", 32'(sw_changed), 32'd0);
    reads = 0;
    repeat (4 * P) begin
      next_cycle();
      if (avm_read === 1'b1) reads++;
    end
    chk("no_read_while_disabled", 32'(reads), 32'd0);

    // Re-raise enable mid-period: strobe waits for counter == P-1.
    while ((cyc % P) != 2) next_cycle();
    enable      = 1'b1;
    next_strobe = cyc + 5;
    wait_strobe("reenable_strobe");
    repeat (4) next_cycle();
    chk("reenable_hold_value", 32'(sw_value), 32'h3);

    // Reset in the WAIT cycle abandons the poll.
    avm_readdata = 32'h0000_0005;
    wait_strobe("pre_reset_strobe");
    next_cycle();
    reset = 1'b1;
    next_cycle();
    chk("midrst_value", 32'(sw_value), 32'd0);
    chk("midrst_valid", 32'(sw_valid), 32'd0);
    chk("midrst_changed", 32'(sw_changed), 32'd0);
    chk("midrst_read", 32'(avm_read), 32'd0);
    reset       = 1'b0;
    cyc         = 0;
    next_strobe = P - 1;
    next_cycle();
    chk("midrst_no_pulse1", 32'(sw_changed), 32'd0);
    next_cycle();
    chk("midrst_no_pulse2", 32'(sw_changed), 32'd0);
    v = '{32'h0000_0005, 18'h00000, 1'b0, 1'b0};
    run_poll(v, "postrst0");
    run_poll(v, "postrst1");
    v = '{32'h0000_0005, 18'h00005, 1'b1, 1'b1};
    run_poll(v, "postrst2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
